// File: rtl/ahb_mst_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_mst_ctrl_if
// Bundles the command/response stream and the AHB-Lite master bus of
// ahb_mst_ctrl.
//   master modport : the controller side (drives cmd_ready, rsp_*, mh* outputs)
//   slave modport  : the requester + fabric side (drives cmd_*, mhrdata,
//                    mhready, mhresp)
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_size/cmd_wdata : command stream
//   rsp_valid/rsp_rdata/rsp_err                               : response pulse
//   mhaddr/mhtrans/mhwrite/mhsize/mhburst/mhprot/mhwdata      : AHB outputs
//   mhrdata/mhready/mhresp                                    : AHB inputs
// ---------------------------------------------------------------------------
interface ahb_mst_ctrl_if #(
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    cmd_size;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mhaddr;
    logic [1:0]    mhtrans;
    logic          mhwrite;
    logic [2:0]    mhsize;
    logic [2:0]    mhburst;
    logic [3:0]    mhprot;
    logic [31:0]   mhwdata;
    logic [31:0]   mhrdata;
    logic          mhready;
    logic          mhresp;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  mhrdata, mhready, mhresp,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output mhaddr, mhtrans, mhwrite, mhsize, mhburst, mhprot, mhwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output mhrdata, mhready, mhresp,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mhaddr, mhtrans, mhwrite, mhsize, mhburst, mhprot, mhwdata
    );
endinterface

// File: rtl/ahb_mst_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_mst_ctrl
// AHB-Lite initiator. Converts a valid/ready command stream of single reads
// and writes into pipelined AHB SINGLE transfers and returns exactly one
// response per command, in command order. The address phase of command N+1
// overlaps the data phase of command N; wait states stall the whole pipe and
// the two-cycle ERROR response cancels a command already in address phase.
// Ports:
//   clk  : bus clock, all logic on posedge
//   rst  : asynchronous active-high reset
//   bus  : ahb_mst_ctrl_if.master (command, response and AHB master signals)
// Parameters:
//   AW   : address width
//   PROT : constant HPROT value
// ---------------------------------------------------------------------------
module ahb_mst_ctrl #(
    parameter int         AW   = 32,
    parameter logic [3:0] PROT = 4'b0011
) (
    input  logic           clk,
    input  logic           rst,
    ahb_mst_ctrl_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Address-phase stage: what is currently presented on HADDR/HTRANS.
    logic          r_ap_valid;
    logic [AW-1:0] r_ap_addr;
    logic          r_ap_write;
    logic [1:0]    r_ap_size;
    logic [31:0]   r_ap_wdata;

    // Data-phase stage: only the byte-lane bits of the address matter here.
    logic          r_dp_valid;
    logic [1:0]    r_dp_lane;
    logic          r_dp_write;
    logic [1:0]    r_dp_size;
    logic [31:0]   r_dp_wdata;

    // Set when an ERROR dropped the command in address phase; that command
    // still owes the requester an error response.
    logic          r_cancel;

    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_rdata;

    logic          w_cmd_ready;
    logic          w_cmd_accept;
    logic          w_err_first;
    logic          w_cancel_rsp;

    // Extract the addressed lane of HRDATA, zero-extended and LSB-justified.
    function automatic logic [31:0] f_rd_lane(input logic [31:0] rd,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
        logic [31:0] res;
        res = 32'h0000_0000;
        case (size)
            2'd0: begin
                case (lane)
                    2'd0:    res = {24'h00_0000, rd[7:0]};
                    2'd1:    res = {24'h00_0000, rd[15:8]};
                    2'd2:    res = {24'h00_0000, rd[23:16]};
                    2'd3:    res = {24'h00_0000, rd[31:24]};
                    default: res = 32'h0000_0000;
                endcase
            end
            2'd1: begin
                if (lane[1]) begin
                    res = {16'h0000, rd[31:16]};
                end else begin
                    res = {16'h0000, rd[15:0]};
                end
            end
            default: res = rd;
        endcase
        return res;
    endfunction

    // Replicate LSB-justified write data across all lanes so the slave finds
    // it on whichever lane the address selects.
    function automatic logic [31:0] f_wd_rep(input logic [31:0] wd,
                                             input logic [1:0]  size);
        logic [31:0] res;
        case (size)
            2'd0:    res = {4{wd[7:0]}};
            2'd1:    res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Handshake and error-phase decode.
    always_comb begin
        w_cmd_ready  = bus.mhready & ~r_cancel & ~rst;
        w_cmd_accept = bus.cmd_valid & w_cmd_ready;
        // First ERROR cycle: HRESP high while HREADY is still low.
        w_err_first  = r_dp_valid & bus.mhresp & ~bus.mhready;
        // The cancelled command answers once the errored one has drained.
        w_cancel_rsp = r_cancel & ~r_dp_valid;
    end

    // Address/data pipeline: advances only when HREADY is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ap_valid <= 1'b0;
            r_ap_addr  <= {AW{1'b0}};
            r_ap_write <= 1'b0;
            r_ap_size  <= 2'd0;
            r_ap_wdata <= 32'h0000_0000;
            r_dp_valid <= 1'b0;
            r_dp_lane  <= 2'd0;
            r_dp_write <= 1'b0;
            r_dp_size  <= 2'd0;
            r_dp_wdata <= 32'h0000_0000;
        end else if (bus.mhready) begin
            r_dp_valid <= r_ap_valid;
            r_dp_lane  <= r_ap_addr[1:0];
            r_dp_write <= r_ap_write;
            r_dp_size  <= r_ap_size;
            r_dp_wdata <= r_ap_wdata;
            if (w_cmd_accept) begin
                r_ap_valid <= 1'b1;
                r_ap_addr  <= bus.cmd_addr;
                r_ap_write <= bus.cmd_write;
                r_ap_size  <= bus.cmd_size;
                r_ap_wdata <= bus.cmd_wdata;
            end else begin
                r_ap_valid <= 1'b0;
            end
        end else if (w_err_first) begin
            // Drive IDLE in the second ERROR cycle; the rest of AP is kept.
            r_ap_valid <= 1'b0;
        end else begin
            r_ap_valid <= r_ap_valid;
        end
    end

    // Cancel flag for the command dropped by an ERROR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cancel <= 1'b0;
        end else if (w_err_first && r_ap_valid) begin
            r_cancel <= 1'b1;
        end else if (w_cancel_rsp) begin
            r_cancel <= 1'b0;
        end else begin
            r_cancel <= r_cancel;
        end
    end

    // Response register: one pulse per completed or cancelled command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else if (r_dp_valid && bus.mhready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= bus.mhresp;
            if (!r_dp_write && !bus.mhresp) begin
                r_rsp_rdata <= f_rd_lane(bus.mhrdata, r_dp_lane, r_dp_size);
            end else begin
                r_rsp_rdata <= 32'h0000_0000;
            end
        end else if (w_cancel_rsp) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mhaddr    = r_ap_addr;
    assign bus.mhtrans   = r_ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.mhwrite   = r_ap_write;
    assign bus.mhsize    = {1'b0, r_ap_size};
    assign bus.mhburst   = 3'b000;
    assign bus.mhprot    = PROT;
    assign bus.mhwdata   = f_wd_rep(r_dp_wdata, r_dp_size);

endmodule
